// File: rtl/id_branch_unit.sv
// IF/ID pipeline register with BEQ/BNE resolution in decode, wrong-path squash
// and a saturating taken-branch counter.
module id_branch_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] if_PC,
  input  logic [WIDTH-1:0] if_instruction,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  output logic [WIDTH-1:0] id_PC,
  output logic [WIDTH-1:0] id_instruction,
  output logic             id_valid,
  output logic             Br_taken,
  output logic [15:0]      Br_offset,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [5:0]       OP_BEQ  = 6'b000100;
  localparam logic [5:0]       OP_BNE  = 6'b000101;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_instr;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       w_op;
  logic             w_is_br;
  logic             w_cond;
  logic             w_taken;
  logic [15:0]      w_offset;

  // Branch decode and condition evaluation from the ID register
  always_comb begin
    w_op    = r_instr[31:26];
    w_is_br = 1'b0;
    w_cond  = 1'b0;
    case (w_op)
      OP_BEQ: begin
        w_is_br = 1'b1;
        w_cond  = (rs_val == rt_val);
      end
      OP_BNE: begin
        w_is_br = 1'b1;
        w_cond  = (rs_val != rt_val);
      end
      default: begin
        w_is_br = 1'b0;
        w_cond  = 1'b0;
      end
    endcase
    w_taken = r_valid & w_cond;
    if (w_is_br) begin
      w_offset = {r_instr[13:0], 2'b00};
    end else begin
      w_offset = 16'h0000;
    end
  end

  // Next-state logic: a taken branch sends the following slot into SQUASH
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_taken) begin
          w_state_nxt = ST_SQUASH;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_SQUASH: w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // IF/ID register; the slot entering SQUASH holds the wrong-path fetch, so it becomes a NOP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= {WIDTH{1'b0}};
      r_instr <= {WIDTH{1'b0}};
      r_valid <= 1'b0;
    end else begin
      r_pc <= if_PC;
      if (w_state_nxt == ST_SQUASH) begin
        r_instr <= {WIDTH{1'b0}};
        r_valid <= 1'b0;
      end else begin
        r_instr <= if_instruction;
        r_valid <= 1'b1;
      end
    end
  end

  // Saturating taken-branch counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_taken && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign id_PC          = r_pc;
  assign id_instruction = r_instr;
  assign id_valid       = r_valid;
  assign rs_addr        = r_instr[25:21];
  assign rt_addr        = r_instr[20:16];
  assign Br_taken       = w_taken;
  assign Br_offset      = w_offset;
  assign taken_count    = r_cnt;

endmodule

// File: tb/tb_id_branch_unit.sv
// Directed bench for id_branch_unit: a bench-side fetch/decode model feeds a scoreboard
// queue; a second instance with CNT_W=2 exercises counter saturation.
module tb_id_branch_unit;

  localparam logic [31:0] LW   = 32'h8C010000;
  localparam logic [31:0] ADD  = 32'h01095020;
  localparam logic [31:0] JUNK = 32'h0000FFFF;
  localparam logic [31:0] BEQ3 = 32'h10220003;
  localparam logic [31:0] BEQ1 = 32'h10220001;
  localparam logic [31:0] BNE2 = 32'h14220002;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_PC = 32'h0;
  logic [31:0] if_instruction = 32'h0;
  logic [31:0] rs_val = 32'h0;
  logic [31:0] rt_val = 32'h0;

  logic [4:0]  rs_addr, rt_addr, rs_addr_s, rt_addr_s;
  logic [31:0] id_PC, id_instruction, id_PC_s, id_instruction_s;
  logic        id_valid, Br_taken, id_valid_s, Br_taken_s;
  logic [15:0] Br_offset, Br_offset_s;
  logic [15:0] taken_count;
  logic [1:0]  taken_count_s;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        taken;
    logic [15:0] off;
    logic [4:0]  rsa;
    logic [4:0]  rta;
    logic [15:0] cnt;
    logic [1:0]  cnt_s;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] f_pc = 32'h0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_instr = 32'h0;
  logic        m_valid = 1'b0;
  logic [15:0] m_cnt = 16'h0;
  logic [1:0]  m_cnt_s = 2'd0;
  logic        m_taken = 1'b0;
  logic [15:0] m_off = 16'h0;
  logic [31:0] cur_instr = 32'h0;

  id_branch_unit #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .if_PC(if_PC), .if_instruction(if_instruction),
    .rs_val(rs_val), .rt_val(rt_val), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .id_PC(id_PC), .id_instruction(id_instruction), .id_valid(id_valid),
    .Br_taken(Br_taken), .Br_offset(Br_offset), .taken_count(taken_count)
  );

  id_branch_unit #(.WIDTH(32), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .if_PC(if_PC), .if_instruction(if_instruction),
    .rs_val(rs_val), .rt_val(rt_val), .rs_addr(rs_addr_s), .rt_addr(rt_addr_s),
    .id_PC(id_PC_s), .id_instruction(id_instruction_s), .id_valid(id_valid_s),
    .Br_taken(Br_taken_s), .Br_offset(Br_offset_s), .taken_count(taken_count_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected decode outputs for the current ID contents of the model.
  function automatic exp_t build(input logic [31:0] rs, input logic [31:0] rt);
    exp_t       e;
    logic [5:0] op;
    logic       cond;
    logic       br;
    op   = m_instr[31:26];
    br   = (op == 6'b000100) || (op == 6'b000101);
    cond = (op == 6'b000100) ? (rs == rt) : (op == 6'b000101) ? (rs != rt) : 1'b0;
    e.pc    = m_pc;
    e.instr = m_instr;
    e.valid = m_valid;
    e.taken = m_valid & cond;
    e.off   = br ? {m_instr[13:0], 2'b00} : 16'h0000;
    e.rsa   = m_instr[25:21];
    e.rta   = m_instr[20:16];
    e.cnt   = m_cnt;
    e.cnt_s = m_cnt_s;
    return e;
  endfunction

  task automatic check_sb();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      chk("id_PC", id_PC, e.pc);
      chk("id_instruction", id_instruction, e.instr);
      chk("id_valid", {31'd0, id_valid}, {31'd0, e.valid});
      chk("Br_taken", {31'd0, Br_taken}, {31'd0, e.taken});
      chk("Br_offset", {16'd0, Br_offset}, {16'd0, e.off});
      chk("rs_addr", {27'd0, rs_addr}, {27'd0, e.rsa});
      chk("rt_addr", {27'd0, rt_addr}, {27'd0, e.rta});
      chk("taken_count", {16'd0, taken_count}, {16'd0, e.cnt});
      chk("taken_count_sat", {30'd0, taken_count_s}, {30'd0, e.cnt_s});
      chk("Br_taken_sat_inst", {31'd0, Br_taken_s}, {31'd0, e.taken});
    end
  endtask

  // Present a fetch and register operands for the instruction in ID, then check.
  task automatic drive(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    if_PC          = f_pc;
    if_instruction = instr;
    rs_val         = rs;
    rt_val         = rt;
    cur_instr      = instr;
    e = build(rs, rt);
    sb.push_back(e);
    m_taken = e.taken;
    m_off   = e.off;
    #1;
    check_sb();
  endtask

  // Advance one clock and update the bench fetch/decode model.
  task automatic tick();
    @(posedge clk);
    m_pc = f_pc;
    if (m_taken) begin
      m_instr = 32'h0;
      m_valid = 1'b0;
      f_pc    = f_pc + {16'h0, m_off};
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (m_cnt_s != 2'd3) m_cnt_s = m_cnt_s + 2'd1;
    end else begin
      m_instr = cur_instr;
      m_valid = 1'b1;
      f_pc    = f_pc + 32'd4;
    end
    #1;
  endtask

  initial begin
    drive(LW, 32'd0, 32'd0);
    chk("reset_taken", {31'd0, Br_taken}, 32'd0);
    #1 rst = 1'b0;
    tick();
    drive(JUNK, 32'd5, 32'd5);
    chk("first_valid", {31'd0, id_valid}, 32'd1);
    chk("first_pc", id_PC, 32'h0);
    tick();
    drive(ADD, 32'd1, 32'd1);
    chk("nonbranch_off", {16'd0, Br_offset}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(32'h0, 32'd1, 32'd1);
      tick();
    end
    drive(BEQ3, 32'd1, 32'd1);
    chk("zero_op_taken", {31'd0, Br_taken}, 32'd0);
    tick();
    drive(BEQ3, 32'd5, 32'd5);
    chk("beq_pc", id_PC, 32'h20);
    chk("beq_taken", {31'd0, Br_taken}, 32'd1);
    chk("beq_off", {16'd0, Br_offset}, 32'h000C);
    tick();
    drive(BEQ3, 32'd5, 32'd5);
    chk("squash_valid", {31'd0, id_valid}, 32'd0);
    chk("squash_instr", id_instruction, 32'h0);
    tick();
    drive(ADD, 32'd5, 32'd6);
    chk("target_pc", id_PC, 32'h30);
    chk("beq_nt_taken", {31'd0, Br_taken}, 32'd0);
    chk("beq_nt_off", {16'd0, Br_offset}, 32'h000C);
    tick();
    drive(BNE2, 32'd3, 32'd3);
    chk("nt_next_pc", id_PC, 32'h34);
    chk("nt_next_valid", {31'd0, id_valid}, 32'd1);
    tick();
    drive(ADD, 32'd1, 32'd2);
    chk("bne_taken", {31'd0, Br_taken}, 32'd1);
    chk("bne_off", {16'd0, Br_offset}, 32'h0008);
    tick();
    drive(BNE2, 32'd4, 32'd4);
    tick();
    drive(BEQ3, 32'd7, 32'd7);
    chk("bne_eq_taken", {31'd0, Br_taken}, 32'd0);
    tick();
    drive(BEQ1, 32'd9, 32'd9);
    chk("b2b_first_taken", {31'd0, Br_taken}, 32'd1);
    tick();
    drive(BEQ1, 32'd9, 32'd9);
    chk("b2b_squash_taken", {31'd0, Br_taken}, 32'd0);
    tick();
    drive(ADD, 32'd9, 32'd9);
    chk("b2b_second_pc", id_PC, 32'h58);
    chk("b2b_second_taken", {31'd0, Br_taken}, 32'd1);
    tick();
    drive(BNE2, 32'd0, 32'd0);
    chk("b2b_count", {16'd0, taken_count}, 32'd4);
    tick();
    drive(ADD, 32'd1, 32'd2);
    tick();
    drive(ADD, 32'd0, 32'd0);
    chk("count_five", {16'd0, taken_count}, 32'd5);
    chk("count_sat", {30'd0, taken_count_s}, 32'd3);
    tick();
    drive(BEQ3, 32'd2, 32'd2);
    tick();
    drive(ADD, 32'd2, 32'd2);
    chk("pre_rst_taken", {31'd0, Br_taken}, 32'd1);
    #1 rst = 1'b1;
    m_pc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
    m_cnt = 16'h0; m_cnt_s = 2'd0; m_taken = 1'b0; f_pc = 32'h0;
    #1;
    sb.push_back(build(rs_val, rt_val));
    check_sb();
    chk("async_rst_taken", {31'd0, Br_taken}, 32'd0);
    #1 rst = 1'b0;
    drive(LW, 32'd0, 32'd0);
    tick();
    drive(ADD, 32'd0, 32'd0);
    chk("post_rst_valid", {31'd0, id_valid}, 32'd1);
    chk("post_rst_instr", id_instruction, LW);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
